// File: rtl/axis_spi_e727_rx.sv
// E727 SPI frame receiver: oversampled deserialiser with word/frame length checks,
// delivering accepted words on an AXI4-Stream master through a small FIFO.
module axis_spi_e727_rx #(
  parameter int unsigned WORDS_PER_FRAME = 7,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ssel,
  input  logic        spi_ldat,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        word_err,
  output logic        frame_err,
  output logic        overflow
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  WPF      = 4'(WORDS_PER_FRAME);
  localparam logic [3:0]  LAST_IDX = 4'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic ssel_meta_q, ssel_sync_q, ssel_prev_q;
  logic ldat_meta_q, ldat_sync_q, ldat_prev_q;

  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  idx_q, idx_d;

  logic push_req, push_tlast, werr, ferr;
  logic sclk_rise, ssel_rise, ldat_rise;

  logic [16:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, pop, push_ok;

  // Reset values mirror an idle link except ldat, so a frame in progress keeps us in WAIT.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sclk_meta_q <= 1'b0; sclk_sync_q <= 1'b0; sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0; mosi_sync_q <= 1'b0;
      ssel_meta_q <= 1'b1; ssel_sync_q <= 1'b1; ssel_prev_q <= 1'b1;
      ldat_meta_q <= 1'b0; ldat_sync_q <= 1'b0; ldat_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns this chain into a shift of one stage per clock.
      sclk_meta_q <= spi_sclk; sclk_sync_q <= sclk_meta_q; sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi_mosi; mosi_sync_q <= mosi_meta_q;
      ssel_meta_q <= spi_ssel; ssel_sync_q <= ssel_meta_q; ssel_prev_q <= ssel_sync_q;
      ldat_meta_q <= spi_ldat; ldat_sync_q <= ldat_meta_q; ldat_prev_q <= ldat_sync_q;
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign ssel_rise = ssel_sync_q & ~ssel_prev_q;
  assign ldat_rise = ldat_sync_q & ~ldat_prev_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_WAIT;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    // NOTE: assigning every output a default first means no path leaves a signal
    // unassigned, so no latch can be inferred.
    state_d = state_q;
    unique case (state_q)
      ST_WAIT:  if (ldat_sync_q)  state_d = ST_IDLE;
      ST_IDLE:  if (!ldat_sync_q) state_d = ST_FRAME;
      ST_FRAME: if (ldat_sync_q)  state_d = ST_IDLE;
      default:                    state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    push_req  = 1'b0;
    werr      = 1'b0;
    ferr      = 1'b0;
    if (state_q == ST_IDLE && !ldat_sync_q) begin
      bit_cnt_d = '0;
      idx_d     = '0;
    end else if (state_q == ST_FRAME) begin
      if (sclk_rise && !ssel_sync_q) begin
        shreg_d   = {shreg_q[14:0], mosi_sync_q};
        bit_cnt_d = (bit_cnt_q == 5'd17) ? 5'd17 : bit_cnt_q + 5'd1;
      end
      if (ssel_rise) begin
        bit_cnt_d = '0;
        if (bit_cnt_q == 5'd16) begin
          if (idx_q < WPF) begin
            push_req = 1'b1;
            idx_d    = idx_q + 4'd1;
          end else begin
            ferr = 1'b1;
          end
        end else begin
          werr = 1'b1;
        end
      end
      // Frame check uses the index after any word ending in this same cycle.
      if (ldat_rise && idx_d != WPF) ferr = 1'b1;
    end
  end

  assign push_tlast = (idx_q == LAST_IDX);
  assign word_err   = werr;
  assign frame_err  = ferr;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & m_axis_tready;
  assign push_ok    = push_req & (~fifo_full | pop);
  assign overflow   = push_req & fifo_full & ~pop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage needs no reset; the pointers alone define which entries are valid.
  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= {push_tlast, shreg_q};
  end

  assign m_axis_tvalid = ~fifo_empty;
  assign {m_axis_tlast, m_axis_tdata} = fifo_empty ? 17'd0 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_axis_spi_e727_rx.sv
// Self-checking bench for axis_spi_e727_rx: directed and random frames compared
// against a word-list model of the frame and FIFO rules.
module tb_axis_spi_e727_rx;

  localparam int W     = 7;
  localparam int DEPTH = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        spi_sclk, spi_mosi, spi_ssel, spi_ldat;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic        word_err, frame_err, overflow;

  axis_spi_e727_rx #(.WORDS_PER_FRAME(W), .FIFO_DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_ssel      (spi_ssel),
    .spi_ldat      (spi_ldat),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .word_err      (word_err),
    .frame_err     (frame_err),
    .overflow      (overflow)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] out_q[$];
  logic [16:0] exp_q[$];
  int werr_cnt, ferr_cnt, ovf_cnt;
  int exp_werr, exp_ferr, exp_ovf;
  logic [15:0] f_data[$];
  int          f_bits[$];
  bit rand_ready_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Observe the stream and error pulses mid-cycle, away from the active edge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
      if (word_err)  werr_cnt++;
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rand_ready_en) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic clear_obs();
    out_q.delete();
    werr_cnt = 0; ferr_cnt = 0; ovf_cnt = 0;
  endtask

  // Transmitter: 4-cycle sclk phases, MSB first; ldat rises with ssel on the last word.
  task automatic tx_word(input logic [15:0] data, input int nbits, input bit last);
    spi_ssel = 1'b0;
    wait_cyc(4);
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = data[15 - (b % 16)];
      wait_cyc(4);
      spi_sclk = 1'b1;
      wait_cyc(4);
      spi_sclk = 1'b0;
    end
    wait_cyc(4);
    spi_ssel = 1'b1;
    if (last) spi_ldat = 1'b1;
    wait_cyc(6);
  endtask

  task automatic run_frame();
    spi_ldat = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < f_data.size(); i++) tx_word(f_data[i], f_bits[i], i == f_data.size() - 1);
    wait_cyc(6);
  endtask

  // Reference: walk the word list; hold_limit > 0 models a stalled sink of that capacity.
  task automatic model_frame(input int hold_limit);
    int idx;
    logic [16:0] acc[$];
    idx = 0;
    exp_q.delete();
    exp_werr = 0; exp_ferr = 0; exp_ovf = 0;
    for (int i = 0; i < f_data.size(); i++) begin
      if (f_bits[i] != 16) exp_werr++;
      else if (idx < W) begin
        acc.push_back({idx == W - 1, f_data[i]});
        idx++;
      end else exp_ferr++;
    end
    if (idx != W) exp_ferr++;
    for (int i = 0; i < acc.size(); i++) begin
      if (hold_limit > 0 && i >= hold_limit) exp_ovf++;
      else exp_q.push_back(acc[i]);
    end
  endtask

  task automatic drain_and_compare(input string name);
    for (int c = 0; c < 500; c++) begin
      if (out_q.size() >= exp_q.size() && !m_axis_tvalid) break;
      wait_cyc(1);
    end
    check({name, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s_w%0d", name, i), 32'(out_q[i]), 32'(exp_q[i]));
    check({name, "_werr"}, 32'(werr_cnt), 32'(exp_werr));
    check({name, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
    check({name, "_ovf"},  32'(ovf_cnt),  32'(exp_ovf));
  endtask

  task automatic load_words(input logic [15:0] d[], input int bits[]);
    f_data.delete(); f_bits.delete();
    for (int i = 0; i < d.size(); i++) begin
      f_data.push_back(d[i]);
      f_bits.push_back(bits[i]);
    end
  endtask

  initial begin
    logic [15:0] nom[] = '{16'h8001, 16'h0000, 16'hFFFF, 16'hA5A5, 16'h5A5A, 16'h1234, 16'hFEDC};
    logic [15:0] long8[];
    int b7[]  = '{16, 16, 16, 16, 16, 16, 16};
    int bs[]  = '{16, 16, 15, 16, 16, 16, 16};
    int b8[]  = '{16, 16, 16, 16, 16, 16, 16, 16};

    aresetn = 1'b0;
    spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ssel = 1'b1; spi_ldat = 1'b1;
    m_axis_tready = 1'b1;
    clear_obs();
    wait_cyc(3);
    check("rst_tvalid", 32'(m_axis_tvalid), 0);
    check("rst_tdata",  32'(m_axis_tdata), 0);
    check("rst_errs",   32'({word_err, frame_err, overflow, m_axis_tlast}), 0);
    aresetn = 1'b1;
    wait_cyc(6);

    load_words(nom, b7);
    clear_obs(); model_frame(0); run_frame(); drain_and_compare("nominal");

    load_words(nom, bs);
    clear_obs(); model_frame(0); run_frame(); drain_and_compare("short_word");

    long8 = new[8];
    for (int i = 0; i < 8; i++) long8[i] = 16'($urandom);
    load_words(long8, b8);
    clear_obs(); model_frame(0); run_frame(); drain_and_compare("long_frame");

    load_words(nom, b7);
    clear_obs(); model_frame(DEPTH);
    m_axis_tready = 1'b0;
    run_frame();
    wait_cyc(10);
    check("bp_held_valid", 32'(m_axis_tvalid), 1);
    check("bp_nothing_popped", 32'(out_q.size()), 0);
    m_axis_tready = 1'b1;
    drain_and_compare("backpressure");

    // Reset mid-frame with words sitting in the FIFO.
    clear_obs();
    m_axis_tready = 1'b0;
    spi_ldat = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < 3; i++) tx_word(nom[i], 16, 1'b0);
    check("pre_rst_valid", 32'(m_axis_tvalid), 1);
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_axis_tvalid), 0);
    check("midrst_tdata",  32'({m_axis_tlast, m_axis_tdata}), 0);
    wait_cyc(3);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    clear_obs();
    for (int i = 3; i < W; i++) tx_word(nom[i], 16, i == W - 1);
    wait_cyc(20);
    check("post_rst_ignored", 32'(out_q.size()), 0);
    check("post_rst_errs", 32'(werr_cnt + ferr_cnt + ovf_cnt), 0);
    load_words(nom, b7);
    clear_obs(); model_frame(0); run_frame(); drain_and_compare("after_reset");

    // Random frames: length, contents, bit counts and sink readiness.
    rand_ready_en = 1'b1;
    for (int t = 0; t < 10; t++) begin
      int n;
      n = int'($urandom_range(5, 9));
      f_data.delete(); f_bits.delete();
      for (int i = 0; i < n; i++) begin
        f_data.push_back(16'($urandom));
        if ($urandom_range(0, 9) < 8) f_bits.push_back(16);
        else f_bits.push_back(($urandom_range(0, 1) == 0) ? 15 : 17);
      end
      clear_obs(); model_frame(0); run_frame();
      drain_and_compare($sformatf("rand%0d", t));
    end
    rand_ready_en = 1'b0;
    m_axis_tready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
